// File: rtl/thee_pg_pkg.sv
// Shared types and helpers for the PGA automatic gain control loop.
package thee_pg_pkg;

  localparam int unsigned GAIN_BITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    SETTLE  = 2'd3
  } agc_state_t;

  // Largest gain code representable in 'bits' bits.
  function automatic int unsigned gain_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/thee_pg_agc_if.sv
// Loop-side signals between the AGC and the PGA model / environment.
interface thee_pg_agc_if
  import thee_pg_pkg::*;
#(
  parameter int unsigned GAIN_BITS = GAIN_BITS_DEF
);

  logic                 en;
  real                  sig_in;
  logic [GAIN_BITS-1:0] dig_gain;
  logic                 gain_upd;
  logic                 locked;
  logic                 at_limit;

  modport master (
    output en, sig_in,
    input  dig_gain, gain_upd, locked, at_limit
  );

  modport slave (
    input  en, sig_in,
    output dig_gain, gain_upd, locked, at_limit
  );

endinterface

// File: rtl/thee_peak_det.sv
// Windowed peak-magnitude detector; flags the cycle holding the last sample.
module thee_peak_det
  import thee_pg_pkg::*;
#(
  parameter int unsigned WIN_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic smp_en_i,
  input  real  sig_i,
  output real  peak_o,
  output logic win_done_c
);

  localparam int unsigned CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  real              peak_q, peak_d, mag_c;

  // Running max of |sig_i|; the count wraps as the window closes.
  always_comb begin
    mag_c      = (sig_i < 0.0) ? -sig_i : sig_i;
    peak_d     = peak_q;
    cnt_d      = cnt_q;
    win_done_c = 1'b0;
    if (clr_i) begin
      peak_d = 0.0;
      cnt_d  = '0;
    end else if (smp_en_i) begin
      if (mag_c > peak_q) peak_d = mag_c;
      win_done_c = (32'(cnt_q) + 32'd1 >= WIN_LEN);
      cnt_d      = win_done_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= 0.0;
      cnt_q  <= '0;
    end else begin
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/thee_pg_agc.sv
// Automatic gain controller stepping the PGA code to keep its peak in band.
// Optional build macro THEE_PG_AGC_LOCK_FREEZE_EN: once locked, only down-steps allowed.
module thee_pg_agc
  import thee_pg_pkg::*;
#(
  parameter int unsigned GAIN_BITS  = GAIN_BITS_DEF,
  parameter int unsigned INIT_GAIN  = 0,
  parameter int unsigned WIN_LEN    = 16,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned LOCK_WINS  = 4,
  parameter real         HI_THR     = 0.9,
  parameter real         LO_THR     = 0.3
) (
  input logic          clk,
  input logic          rst,
  thee_pg_agc_if.slave bus
);

  localparam logic [GAIN_BITS-1:0] GMAX  = GAIN_BITS'(gain_max(GAIN_BITS));
  localparam logic [GAIN_BITS-1:0] GINIT = GAIN_BITS'(INIT_GAIN);
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned LCK_W = $clog2(LOCK_WINS + 1);
  localparam logic [LCK_W-1:0] LOCK_SAT = LCK_W'(LOCK_WINS);

  if (!(LO_THR < HI_THR)) begin : g_thr_chk
    $error("thee_pg_agc: LO_THR must be strictly below HI_THR");
  end
  if (WIN_LEN < 1) begin : g_win_chk
    $error("thee_pg_agc: WIN_LEN must be at least 1");
  end

  agc_state_t           state_q, state_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic                 upd_q, upd_d;
  logic                 locked_q, locked_d;
  logic                 at_lim_q, at_lim_d;
  logic [LCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [SET_W-1:0]     set_cnt_q, set_cnt_d;

  real  peak_c;
  logic win_done_c;
  logic dn_req_c, up_req_c, up_ok_c;

  thee_peak_det #(
    .WIN_LEN (WIN_LEN)
  ) u_peak (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q != MEASURE),
    .smp_en_i   (state_q == MEASURE),
    .sig_i      (bus.sig_in),
    .peak_o     (peak_c),
    .win_done_c (win_done_c)
  );

`ifdef THEE_PG_AGC_LOCK_FREEZE_EN
  assign up_ok_c = ~locked_q;
`else
  assign up_ok_c = 1'b1;
`endif

  assign dn_req_c = (peak_c > HI_THR);
  assign up_req_c = (peak_c < LO_THR);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    upd_d      = 1'b0;
    locked_d   = locked_q;
    at_lim_d   = at_lim_q;
    lock_cnt_d = lock_cnt_q;
    set_cnt_d  = set_cnt_q;

    unique case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
        if (bus.en) state_d = MEASURE;
      end

      MEASURE: begin
        if (win_done_c) state_d = DECIDE;
      end

      DECIDE: begin
        if ((dn_req_c && gain_q != '0) ||
            (up_req_c && gain_q != GMAX && up_ok_c)) begin
          gain_d     = dn_req_c ? gain_q - GAIN_BITS'(1) : gain_q + GAIN_BITS'(1);
          upd_d      = 1'b1;
          at_lim_d   = 1'b0;
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          set_cnt_d  = '0;
          state_d    = (SETTLE_CYC == 0) ? MEASURE : SETTLE;
        end else begin
          at_lim_d   = (dn_req_c && gain_q == '0) || (up_req_c && gain_q == GMAX);
          lock_cnt_d = (lock_cnt_q == LOCK_SAT) ? lock_cnt_q : lock_cnt_q + LCK_W'(1);
          locked_d   = (lock_cnt_d == LOCK_SAT);
          state_d    = MEASURE;
        end
      end

      SETTLE: begin
        if (32'(set_cnt_q) + 32'd1 >= SETTLE_CYC) begin
          set_cnt_d = '0;
          state_d   = MEASURE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Dropping enable abandons the loop but keeps the current gain code.
    if (state_q != IDLE && !bus.en) begin
      state_d    = IDLE;
      gain_d     = gain_q;
      upd_d      = 1'b0;
      at_lim_d   = at_lim_q;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      set_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gain_q     <= GINIT;
      upd_q      <= 1'b0;
      locked_q   <= 1'b0;
      at_lim_q   <= 1'b0;
      lock_cnt_q <= '0;
      set_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      upd_q      <= upd_d;
      locked_q   <= locked_d;
      at_lim_q   <= at_lim_d;
      lock_cnt_q <= lock_cnt_d;
      set_cnt_q  <= set_cnt_d;
    end
  end

  assign bus.dig_gain = gain_q;
  assign bus.gain_upd = upd_q;
  assign bus.locked   = locked_q;
  assign bus.at_limit = at_lim_q;

endmodule

// File: tb/tb_thee_pg_agc.sv
// Bench for thee_pg_agc: loop-level reference model plus directed scenarios.
module tb_thee_pg_agc;

  localparam int unsigned GB    = 3;
  localparam int unsigned INIT  = 2;
  localparam int unsigned WIN   = 16;
  localparam int unsigned SET   = 4;
  localparam int unsigned LOCK  = 4;
  localparam real         HI    = 0.9;
  localparam real         LO    = 0.3;
  localparam int          GMAX  = 7;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  thee_pg_agc_if #(.GAIN_BITS(GB)) bus ();

  thee_pg_agc #(
    .GAIN_BITS  (GB),
    .INIT_GAIN  (INIT),
    .WIN_LEN    (WIN),
    .SETTLE_CYC (SET),
    .LOCK_WINS  (LOCK),
    .HI_THR     (HI),
    .LO_THR     (LO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Reference model: ph = position in the loop (0 idle, 1..WIN sampling,
  // WIN+1 deciding, then SET settle cycles). Values are those seen after each edge.
  int  m_gain, m_holds, ph;
  bit  m_upd, m_lock, m_at, m_live = 1'b0;
  real win[WIN];

  function automatic real mag(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  always @(posedge clk) begin
    real pk;
    bit  want_dn, want_up, frozen;
    m_upd = 1'b0;
    if (rst) begin
      m_gain = INIT; m_lock = 0; m_at = 0; m_holds = 0; ph = 0; m_live = 1'b1;
    end else if (ph == 0) begin
      m_holds = 0; m_lock = 0;
      if (bus.en) ph = 1;
    end else if (!bus.en) begin
      ph = 0; m_holds = 0; m_lock = 0;
    end else if (ph <= WIN) begin
      win[ph-1] = mag(bus.sig_in);
      ph++;
    end else if (ph == WIN + 1) begin
      pk = 0.0;
      foreach (win[i]) if (win[i] > pk) pk = win[i];
      want_dn = (pk > HI);
      want_up = (pk < LO);
`ifdef THEE_PG_AGC_LOCK_FREEZE_EN
      frozen = m_lock;
`else
      frozen = 1'b0;
`endif
      if ((want_dn && m_gain > 0) || (want_up && m_gain < GMAX && !frozen)) begin
        m_gain  = want_dn ? m_gain - 1 : m_gain + 1;
        m_upd   = 1'b1;
        m_at    = 1'b0;
        m_holds = 0;
        m_lock  = 1'b0;
        ph      = (SET > 0) ? WIN + 2 : 1;
      end else begin
        m_at    = (want_dn && m_gain == 0) || (want_up && m_gain == GMAX);
        m_holds = (m_holds < LOCK) ? m_holds + 1 : LOCK;
        m_lock  = (m_holds == LOCK);
        ph      = 1;
      end
    end else begin
      ph = (ph == WIN + 1 + SET) ? 1 : ph + 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model.dig_gain", 32'(bus.dig_gain), 32'(m_gain));
      chk("model.gain_upd", 32'(bus.gain_upd), 32'(m_upd));
      chk("model.locked",   32'(bus.locked),   32'(m_lock));
      chk("model.at_limit", 32'(bus.at_limit), 32'(m_at));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  // Raise enable while idle; the next edge is edge 0, after which cycle 1 begins.
  task automatic start(input real s);
    bus.sig_in = s;
    bus.en     = 1'b1;
    cyc        = 0;
  endtask

  task automatic abort_at(input int c);
    go_to(c);
    bus.en = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.sig_in = 0.0;

    // Reset values
    tick(); tick();
    chk("rst.dig_gain", 32'(bus.dig_gain), 2);
    chk("rst.gain_upd", 32'(bus.gain_upd), 0);
    chk("rst.locked",   32'(bus.locked),   0);
    chk("rst.at_limit", 32'(bus.at_limit), 0);
    rst = 1'b0;
    tick();

    // In band: no steps, lock after four holds
    start(0.5);
    go_to(18); chk("band.no_upd18", 32'(bus.gain_upd), 0);
    go_to(68); chk("band.locked68", 32'(bus.locked), 0);
    go_to(69); chk("band.locked69", 32'(bus.locked), 1);
               chk("band.gain69",   32'(bus.dig_gain), 2);
    bus.sig_in = 0.1;
    go_to(86);
`ifdef THEE_PG_AGC_LOCK_FREEZE_EN
    chk("freeze.gain",   32'(bus.dig_gain), 2);
    chk("freeze.locked", 32'(bus.locked),   1);
    chk("freeze.upd",    32'(bus.gain_upd), 0);
`else
    chk("track.gain",   32'(bus.dig_gain), 3);
    chk("track.locked", 32'(bus.locked),   0);
    chk("track.upd",    32'(bus.gain_upd), 1);
`endif
    // Reset lands in the settle period of the tracking build
    go_to(87);
    rst    = 1'b1;
    bus.en = 1'b0;
    tick();
    chk("rstmid.gain", 32'(bus.dig_gain), 2);
    chk("rstmid.upd",  32'(bus.gain_upd), 0);
    chk("rstmid.lock", 32'(bus.locked),   0);
    rst = 1'b0;
    tick();

    // Single spike above HI_THR, then exactly HI_THR and exactly LO_THR
    start(0.5);
    go_to(4);  bus.sig_in = -1.2;
    tick();    bus.sig_in = 0.5;
    go_to(17); chk("spike.gain17", 32'(bus.dig_gain), 2);
    go_to(18); chk("spike.gain18", 32'(bus.dig_gain), 1);
               chk("spike.upd18",  32'(bus.gain_upd), 1);
    bus.sig_in = 0.9;
    go_to(19); chk("spike.upd19",  32'(bus.gain_upd), 0);
    go_to(39); chk("hi_eq.gain",   32'(bus.dig_gain), 1);
               chk("hi_eq.upd",    32'(bus.gain_upd), 0);
               chk("hi_eq.at",     32'(bus.at_limit), 0);
    bus.sig_in = 0.3;
    go_to(56); chk("lo_eq.gain",   32'(bus.dig_gain), 1);
               chk("lo_eq.upd",    32'(bus.gain_upd), 0);
    abort_at(60);
    chk("abort1.gain", 32'(bus.dig_gain), 1);

    // Low level: climb to max code, hit the limit, then lock
    start(0.1);
    go_to(18);  chk("low.gain18",  32'(bus.dig_gain), 2);
                chk("low.upd18",   32'(bus.gain_upd), 1);
    go_to(19);  chk("low.upd19",   32'(bus.gain_upd), 0);
    go_to(38);  chk("low.upd38",   32'(bus.gain_upd), 0);
    go_to(39);  chk("low.gain39",  32'(bus.dig_gain), 3);
    go_to(60);  chk("low.gain60",  32'(bus.dig_gain), 4);
    go_to(123); chk("low.gain123", 32'(bus.dig_gain), 7);
    go_to(144); chk("low.at144",   32'(bus.at_limit), 1);
                chk("low.upd144",  32'(bus.gain_upd), 0);
    go_to(194); chk("low.lock194", 32'(bus.locked),   0);
    go_to(195); chk("low.lock195", 32'(bus.locked),   1);
    abort_at(200);
    chk("abort2.gain",   32'(bus.dig_gain), 7);
    chk("abort2.locked", 32'(bus.locked),   0);
    chk("abort2.at",     32'(bus.at_limit), 1);

    // High level: step clears at_limit, walk down to code 0 and hit the floor
    start(1.5);
    go_to(18);  chk("high.gain18", 32'(bus.dig_gain), 6);
                chk("high.at18",   32'(bus.at_limit), 0);
                chk("high.upd18",  32'(bus.gain_upd), 1);
    go_to(144); chk("high.gain144", 32'(bus.dig_gain), 0);
    go_to(165); chk("high.at165",  32'(bus.at_limit), 1);
                chk("high.gain165", 32'(bus.dig_gain), 0);
                chk("high.upd165", 32'(bus.gain_upd), 0);
    abort_at(170);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
